// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial adder/subtractor built around one full-adder cell. Operands are
// captured on a start strobe and consumed LSB-first, one bit per clock. When
// the last bit is processed the result, carry-out and signed overflow are
// registered and a one-cycle done pulse is raised. The registered results
// hold until the next operation completes or until reset.
//
// Parameters:
//   WIDTH  operand/result width in bits (2..32)
//
// Ports:
//   clk    system clock, rising edge
//   rst    synchronous active-high reset
//   start  request, only sampled while idle
//   sub    0 = a + b + cin, 1 = a - b (sampled with start)
//   a, b   operands (sampled with start)
//   cin    carry-in for add mode, ignored when subtracting
//   busy   high from acceptance through the done cycle
//   done   one-cycle pulse marking a fresh result
//   sum    registered result (modulo 2^WIDTH)
//   cout   carry-out; in subtract mode 1 means no borrow
//   ovf    signed two's-complement overflow
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic [CW-1:0]    count;

  logic             bit_sum;
  logic             bit_carry;
  logic [WIDTH-1:0] next_result;

  // The single full-adder cell working on the current LSBs, plus the result
  // register after this bit has been shifted in at the top.
  always_comb begin
    bit_sum     = op_a[0] ^ op_b[0] ^ carry;
    bit_carry   = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    next_result = (result >> 1) | (WIDTH'(bit_sum) << (WIDTH - 1));
  end

  // Control FSM and datapath. Subtraction is done as a + ~b + 1, so the
  // inverted operand and a forced carry-in are set up at acceptance. On the
  // last bit, the carry entering that bit is the carry into the MSB, so
  // overflow is simply that carry XOR the final carry-out and is loaded
  // straight into the output register together with the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      carry  <= 1'b0;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub | cin;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          op_a   <= op_a >> 1;
          op_b   <= op_b >> 1;
          carry  <= bit_carry;
          result <= next_result;
          count  <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            sum   <= next_result;
            cout  <= bit_carry;
            ovf   <= carry ^ bit_carry;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
